// File: rtl/fp32_pkg.sv
// fp32_pkg: shared types, constants and helpers for the fp32 adder and the
// streaming accumulator built around it.
//   fp32_t         packed IEEE-754 single {sign, exp, mant}
//   accum_state_t  fp32_accum FSM states
//   fp32_round     round-to-nearest-even of a normalised 27-bit significand
//   fp32_is_nan    true for exp=FF with a non-zero mantissa
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam int          FP32_ADD_LATENCY = 3;
    localparam logic [31:0] FP32_ZERO        = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN        = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } accum_state_t;

    // m[26] is the hidden-bit position (0 only for subnormal results, which
    // must then arrive with exp=1), m[2:0] are guard/round/sticky.
    function automatic logic [31:0] fp32_round(input logic       sign,
                                               input logic [9:0] exp,
                                               input logic [26:0] m);
        logic [24:0] r;
        logic [9:0]  e;
        logic        up;
        up = m[2] & (m[1] | m[0] | m[3]);
        r  = {1'b0, m[26:3]} + {24'd0, up};
        e  = exp;
        // Rounding carried out of the significand: renormalise by one.
        if (r[24]) begin
            r = {1'b0, r[24:1]};
            e = e + 10'd1;
        end
        if (e >= 10'd255) begin
            return {sign, 8'hFF, 23'd0};
        end
        // A subnormal that rounded up into the hidden bit becomes exp=1 here.
        return {sign, (r[23] ? e[7:0] : 8'h00), r[22:0]};
    endfunction

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp32_add.sv
// fp32_add: IEEE-754 single-precision adder, round-to-nearest-even, fixed
// LATENCY-cycle pipeline. The pipeline has no reset: results in flight keep
// moving through reset, so consumers must qualify valid_out themselves.
// Ports:
//   clk_in     in   clock
//   valid_in   in   a_in/b_in valid
//   a_in,b_in  in   fp32 operands
//   valid_out  out  c_out valid, LATENCY cycles after valid_in
//   c_out      out  fp32 sum
module fp32_add
    import fp32_pkg::*;
#(
    parameter int LATENCY = FP32_ADD_LATENCY
) (
    input  logic        clk_in,
    input  logic        valid_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        valid_out,
    output logic [31:0] c_out
);

    fp32_t       a, b, x, y;
    logic [9:0]  ex, ey, d, e_n;
    logic [26:0] mx, my, my_sh, m_n;
    logic [27:0] s;
    logic        sticky, same, found;
    logic [4:0]  lz, sh;
    logic [31:0] c_comb;

    always_comb begin
        a      = a_in;
        b      = b_in;
        x      = a;
        y      = b;
        ex     = 10'd0;
        ey     = 10'd0;
        d      = 10'd0;
        e_n    = 10'd0;
        mx     = 27'd0;
        my     = 27'd0;
        my_sh  = 27'd0;
        m_n    = 27'd0;
        s      = 28'd0;
        sticky = 1'b0;
        same   = 1'b0;
        found  = 1'b0;
        lz     = 5'd0;
        sh     = 5'd0;
        c_comb = FP32_ZERO;
        if (a.exp == 8'hFF || b.exp == 8'hFF) begin
            // NaNs are quieted and propagated; inf-inf of opposite sign is invalid.
            if (a.exp == 8'hFF && a.mant != 23'd0) begin
                c_comb = a_in | 32'h0040_0000;
            end else if (b.exp == 8'hFF && b.mant != 23'd0) begin
                c_comb = b_in | 32'h0040_0000;
            end else if (a.exp == 8'hFF && b.exp == 8'hFF && a.sign != b.sign) begin
                c_comb = FP32_QNAN;
            end else if (a.exp == 8'hFF) begin
                c_comb = a_in;
            end else begin
                c_comb = b_in;
            end
        end else begin
            // x is the operand of larger magnitude; it decides the result sign.
            if (b_in[30:0] > a_in[30:0]) begin
                x = b;
                y = a;
            end
            ex = (x.exp == 8'd0) ? 10'd1 : {2'b00, x.exp};
            ey = (y.exp == 8'd0) ? 10'd1 : {2'b00, y.exp};
            mx = {(x.exp != 8'd0), x.mant, 3'b000};
            my = {(y.exp != 8'd0), y.mant, 3'b000};
            d  = ex - ey;
            if (d >= 10'd27) begin
                my_sh = {26'd0, |my};
            end else begin
                sticky = |(my << (10'd27 - d));
                my_sh  = (my >> d) | {26'd0, sticky};
            end
            same = (x.sign == y.sign);
            s    = same ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});
            if (s == 28'd0) begin
                // Exact zero: -0 only when both inputs were negative zeros.
                c_comb = {x.sign & y.sign, 31'd0};
            end else if (s[27]) begin
                m_n    = {s[27:2], s[1] | s[0]};
                e_n    = ex + 10'd1;
                c_comb = fp32_round(x.sign, e_n, m_n);
            end else begin
                for (int i = 26; i >= 0; i--) begin
                    if (!found) begin
                        if (s[i]) found = 1'b1;
                        else      lz    = lz + 5'd1;
                    end
                end
                // Never normalise below exp=1: the rest stays subnormal.
                sh     = ({5'd0, lz} > (ex - 10'd1)) ? 5'(ex - 10'd1) : lz;
                m_n    = s[26:0] << sh;
                e_n    = ex - {5'd0, sh};
                c_comb = fp32_round(x.sign, e_n, m_n);
            end
        end
    end

    logic [LATENCY-1:0] v_pipe;
    logic [31:0]        c_pipe [LATENCY];

    always_ff @(posedge clk_in) begin
        v_pipe[0] <= valid_in;
        c_pipe[0] <= c_comb;
        for (int i = 1; i < LATENCY; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            c_pipe[i] <= c_pipe[i-1];
        end
    end

    assign valid_out = v_pipe[LATENCY-1];
    assign c_out     = c_pipe[LATENCY-1];

endmodule

// File: rtl/fp32_accum.sv
// fp32_accum: streaming fp32 reduction. Accepts a packet of fp32 elements
// (last_in marks the final one) and returns sum = ((x0+x1)+x2)+... computed
// strictly in order through one fp32_add instance, plus the element count.
// Optional build macro FP32_ACCUM_NAN_STICKY_EN: any NaN element forces the
// packet result to canonical qNaN 32'h7FC00000.
// Ports:
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   valid_in/ready_out    input handshake: element moves when both are 1
//   data_in, last_in      fp32 element, final-element marker
//   valid_out/ready_in    output handshake: result moves when both are 1;
//                         valid_out/sum_out/count_out hold until accepted
//   sum_out, count_out    packet sum and saturating element count
//                         (both zero whenever no result is presented)
module fp32_accum
    import fp32_pkg::*;
#(
    parameter int ADD_LATENCY = FP32_ADD_LATENCY,
    parameter int COUNT_W     = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [31:0]        data_in,
    input  logic               last_in,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [31:0]        sum_out,
    output logic [COUNT_W-1:0] count_out
);

    // A WAIT lasting this long means the adder result was lost.
    localparam logic [7:0] WAIT_LIMIT = 8'(ADD_LATENCY + 2);

    accum_state_t       state, state_d;
    logic [31:0]        acc, acc_d;
    logic [COUNT_W-1:0] count, count_d;
    logic               last_q, last_d;
    logic [7:0]         wait_cnt, wait_d;
    logic               take, give;
    logic               add_valid, add_result_valid;
    logic [31:0]        add_sum;

    assign ready_out = (state == IDLE) || (state == ACCUM);
    assign valid_out = (state == DONE);
    assign take      = valid_in && ready_out;
    assign give      = valid_out && ready_in;

    fp32_add #(
        .LATENCY (ADD_LATENCY)
    ) u_add (
        .clk_in    (clk_in),
        .valid_in  (add_valid),
        .a_in      (acc),
        .b_in      (data_in),
        .valid_out (add_result_valid),
        .c_out     (add_sum)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            acc      <= FP32_ZERO;
            count    <= '0;
            last_q   <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_d;
            acc      <= acc_d;
            count    <= count_d;
            last_q   <= last_d;
            wait_cnt <= wait_d;
        end
    end

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        count_d   = count;
        last_d    = last_q;
        wait_d    = wait_cnt;
        add_valid = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    acc_d   = data_in;
                    count_d = COUNT_W'(1);
                    state_d = last_in ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (take) begin
                    add_valid = 1'b1;
                    last_d    = last_in;
                    if (count != '1) count_d = count + 1'b1;
                    wait_d    = 8'd0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // The adder result is only meaningful here; anything it
                // produces in other states is a stale, pre-reset leftover.
                if (add_result_valid) begin
                    acc_d   = add_sum;
                    state_d = last_q ? DONE : ACCUM;
                end else if (wait_cnt != 8'hFF) begin
                    wait_d = wait_cnt + 8'd1;
                end
            end
            DONE: begin
                if (give) begin
                    acc_d   = FP32_ZERO;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FP32_ACCUM_NAN_STICKY_EN
    logic nan_q, nan_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) nan_q <= 1'b0;
        else           nan_q <= nan_d;
    end

    always_comb begin
        nan_d = nan_q;
        if (state == IDLE) begin
            nan_d = take && fp32_is_nan(data_in);
        end else if (state == ACCUM && take) begin
            nan_d = nan_q | fp32_is_nan(data_in);
        end
    end
`endif

    always_comb begin
        sum_out   = FP32_ZERO;
        count_out = '0;
        if (state == DONE) begin
            count_out = count;
`ifdef FP32_ACCUM_NAN_STICKY_EN
            sum_out   = nan_q ? FP32_QNAN : acc;
`else
            sum_out   = acc;
`endif
        end
    end

    watchdog_a : assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(state == WAIT && wait_cnt >= WAIT_LIMIT));

endmodule

// File: tb/tb_fp32_accum.sv
// tb_fp32_accum: randomized and directed bench for fp32_accum. Expected sums
// come from real (double) arithmetic rounded to fp32 with round-to-nearest-even.
module tb_fp32_accum;

    localparam int LAT  = fp32_pkg::FP32_ADD_LATENCY;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int EW   = 81;   // {nan, due_cycle[31:0], count[15:0], sum[31:0]}

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          valid_in;
    logic          ready_out;
    logic [31:0]   data_in;
    logic          last_in;
    logic          valid_out;
    logic          ready_in;
    logic [31:0]   sum_out;
    logic [CW-1:0] count_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int xfer_cyc = 0;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   pkt[$];
    int            waits_q[$];
    logic          ready_mode  = 1'b0;
    logic          ready_force = 1'b1;

    fp32_accum #(
        .ADD_LATENCY (LAT),
        .COUNT_W     (CW)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .last_in   (last_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .sum_out   (sum_out),
        .count_out (count_out)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Downstream ready: either a fixed level or random back-pressure.
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            ready_in = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // ---------------- reference model ----------------
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] b;
        if (x[30:23] == 8'd0) b = {x[31], 63'd0};
        else                  b = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [24:0] m;
        logic        up;
        int          e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e  = int'(b[62:52]) - 896;
        up = b[28] && ((b[27:0] != 28'd0) || b[29]);
        m  = {2'b01, b[51:29]} + 25'(up);
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {b[63], 8'hFF, 23'd0};
        if (e <= 0)   return {b[63], 31'd0};
        return {b[63], 8'(e), m[22:0]};
    endfunction

    // A double holds the exact-enough sum of two fp32 values, so one
    // rounding to fp32 gives the correctly rounded fp32 sum.
    function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(110, 145));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_elem(input logic [31:0] d, input logic l, input logic keep);
        int n;
        n = 0;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        forever begin
            @(negedge clk_in);
            if (ready_out) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got ready_out=0 for %0d cycles, want 1", n);
                break;
            end
        end
        xfer_cyc = cyc;
        waits_q.push_back(n);
        @(posedge clk_in);
        #1;
        if (!keep) begin
            valid_in = 1'b0;
            last_in  = 1'b0;
        end
    endtask

    task automatic send_packet(input logic keep, input int gap_max);
        logic [31:0] acc;
        logic        nan;
        int          n, due, cnt;
        n   = pkt.size();
        nan = 1'b0;
        acc = 32'd0;
        waits_q.delete();
        for (int i = 0; i < n; i++) begin
            if (is_nan(pkt[i])) nan = 1'b1;
            if (i == 0)    acc = pkt[0];
            else if (!nan) acc = fp_add_model(acc, pkt[i]);
            send_elem(pkt[i], (i == n - 1), keep && (i != n - 1));
            if (!keep && gap_max > 0 && i != n - 1) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk_in);
                    #1;
                end
            end
        end
        due = xfer_cyc + ((n == 1) ? 1 : LAT + 1);
        cnt = (n > CMAX) ? CMAX : n;
        exp_q.push_back({nan, 32'(due), 16'(cnt), acc});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results, want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic          prev_v = 1'b0;
    logic          held   = 1'b0;
    logic [31:0]   h_sum;
    logic [CW-1:0] h_cnt;
    logic [EW-1:0] head;

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            prev_v = 1'b0;
            held   = 1'b0;
        end else begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_valid: got valid_out=1, want 0 (no packet pending)");
                end else begin
                    head = exp_q[0];
                    if (!prev_v) check("latency_cycle", 32'(cyc), head[79:48]);
                    if (held) begin
                        check("hold_sum", sum_out, h_sum);
                        check("hold_count", 32'(count_out), 32'(h_cnt));
                    end
                    if (ready_in) begin
                        if (head[80]) begin
`ifdef FP32_ACCUM_NAN_STICKY_EN
                            check("nan_sum", sum_out, 32'h7FC0_0000);
`else
                            check("nan_sum_is_nan", 32'(is_nan(sum_out)), 32'd1);
`endif
                        end else begin
                            check("sum", sum_out, head[31:0]);
                        end
                        check("count", 32'(count_out), 32'(head[47:32]));
                        void'(exp_q.pop_front());
                        held = 1'b0;
                    end else begin
                        held  = 1'b1;
                        h_sum = sum_out;
                        h_cnt = count_out;
                    end
                end
            end else if (held) begin
                total++;
                bad++;
                $display("FAIL valid_dropped: got valid_out=0 before ready_in, want 1");
                held = 1'b0;
            end
            prev_v = valid_out;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int len;
        logic keep;
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        data_in  = 32'd0;
        last_in  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_sum_out", sum_out, 32'd0);
        check("rst_count_out", 32'(count_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("ready_after_release", 32'(ready_out), 32'd1);

        // model pinned against hand-computed sums
        check("model_pair", fp_add_model(32'h43970FFD, 32'h40C91759), 32'h439A345A);
        check("model_small_diff", fp_add_model(32'h3DE31F8A, 32'hBDD53261), 32'h3BDED290);
        check("model_three_ones",
              fp_add_model(fp_add_model(32'h3F800000, 32'h3F800000), 32'h3F800000), 32'h40400000);

        // single element: result the very next cycle
        pkt = '{32'h40490FDB};
        send_packet(1'b0, 0);
        @(negedge clk_in);
        check("single_valid", 32'(valid_out), 32'd1);
        check("single_sum", sum_out, 32'h40490FDB);
        check("single_count", 32'(count_out), 32'd1);
        wait_drain();

        // two elements: result ADD_LATENCY+1 cycles after last transfer
        pkt = '{32'h43970FFD, 32'h40C91759};
        send_packet(1'b0, 0);
        repeat (LAT + 1) @(negedge clk_in);
        check("pair_valid", 32'(valid_out), 32'd1);
        check("pair_sum", sum_out, 32'h439A345A);
        check("pair_count", 32'(count_out), 32'd2);
        wait_drain();

        // valid held high: third element stalls for the whole WAIT
        pkt = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        send_packet(1'b1, 0);
        check("accum_no_stall", 32'(waits_q[1]), 32'd0);
        check("wait_stall_cycles", 32'(waits_q[2]), 32'(LAT));
        repeat (LAT + 1) @(negedge clk_in);
        check("ones_sum", sum_out, 32'h40400000);
        check("ones_count", 32'(count_out), 32'd3);
        wait_drain();

        // back-pressure: result held stable, then IDLE one cycle after ready_in
        ready_force = 1'b0;
        @(posedge clk_in);
        #1;
        pkt = '{32'h3DE31F8A, 32'hBDD53261};
        send_packet(1'b0, 0);
        repeat (LAT + 1) @(negedge clk_in);
        check("bp_valid", 32'(valid_out), 32'd1);
        check("bp_sum", sum_out, 32'h3BDED290);
        repeat (5) begin
            @(negedge clk_in);
            check("bp_hold_valid", 32'(valid_out), 32'd1);
            check("bp_hold_sum", sum_out, 32'h3BDED290);
        end
        ready_force = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        check("bp_release_valid", 32'(valid_out), 32'd0);
        check("bp_release_ready", 32'(ready_out), 32'd1);
        wait_drain();

        // asynchronous reset while an add is in flight
        send_elem(32'h3F800000, 1'b0, 1'b0);
        send_elem(32'h40000000, 1'b0, 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("midrst_valid_out", 32'(valid_out), 32'd0);
        check("midrst_sum_out", sum_out, 32'd0);
        check("midrst_count_out", 32'(count_out), 32'd0);
        check("midrst_ready_out", 32'(ready_out), 32'd1);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (LAT + 3) @(negedge clk_in);
        check("stray_result_ignored", 32'(valid_out), 32'd0);
        @(posedge clk_in);
        #1;
        pkt = '{32'h3F800000};
        send_packet(1'b0, 0);
        @(negedge clk_in);
        check("post_rst_sum", sum_out, 32'h3F800000);
        wait_drain();

        // NaN element
        pkt = '{32'h7F800001, 32'h3F800000};
        send_packet(1'b0, 0);
        wait_drain();

        // element count saturates at 2**CW-1
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(rand_val());
        send_packet(1'b0, 0);
        wait_drain();

        // random packets with random back-pressure and input gaps
        ready_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len  = $urandom_range(1, 6);
            keep = ($urandom_range(0, 3) == 0);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(rand_val());
            send_packet(keep, keep ? 0 : 2);
        end
        wait_drain();
        ready_mode = 1'b0;
        repeat (3) @(posedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
